ls_access_sequencer: RTL
========================

Name: ls_access_sequencer

Overview:
Multi-cycle controller that sequences byte, halfword and word loads and stores between the CPU control unit and the single-port data memory. Partial stores (byte/half) are done as read-modify-write: read the word, merge the new lane, write it back. Loads return the selected lane zero-extended. The block sits between the main control FSM and memory, and replaces ad-hoc MDR/B merging in the datapath.

Parameters:
MEM_LATENCY, 2, cycles mem_addr must be held before mem_rdata is valid (>=1)
CNT_W, 2, width of latency counter (must hold MEM_LATENCY)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept; high only in IDLE
req_write  in  1  1=store, 0=load
req_size  in  2  01 byte, 10 half, 11 word, 00 illegal
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  load result, zero-extended
resp_err  out  1  qualifies resp_valid: misaligned or illegal size
mem_addr  out  32  word address {addr[31:2],2'b00}
mem_wr  out  1  write strobe, exactly one cycle per store
mem_wdata  out  32  full word to write
mem_rdata  in  32  memory read data
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; resp_valid=0, resp_err=0, resp_rdata=0, mem_addr=0, mem_wr=0, mem_wdata=0, busy=0, req_ready=0 while reset is low. req_ready=1 from the first cycle after release.
- Reset mid-operation: abort immediately. mem_wr deasserts combinationally with the state. No partial write may ever be issued.
- States: IDLE, READ, WRITE, RESP, ERR.
- Accept on the rising edge with req_valid&&req_ready. Latch write, size, addr[1:0] and wdata. Load mem_addr.
- Alignment check at accept:
  - size 00 -> error.
  - half with addr[0]=1 -> error.
  - word with addr[1:0]!=0 -> error.
  - Error -> ERR.
- Non-error routing at accept:
  - Load, or byte/half store -> READ.
  - Word store -> WRITE, with mem_wdata=req_wdata.
- READ: hold mem_addr and mem_wr=0 for exactly MEM_LATENCY cycles, using a down-counter. On the last edge of READ, sample mem_rdata.
  - Load: resp_rdata = lane selected by addr[1:0] (little-endian: lane0=[7:0], lane3=[31:24]), zero-extended. Then -> RESP.
  - Store: mem_wdata = mem_rdata with the addressed byte (addr[1:0]) or half (addr[1]) lane replaced by wdata[7:0]/[15:0]. Then -> WRITE.
- WRITE: one cycle, mem_wr=1, mem_addr and mem_wdata stable -> RESP.
- ERR: one cycle, no memory access (mem_wr=0) -> RESP with resp_err=1.
- RESP: resp_valid=1 for one cycle -> IDLE.
  - resp_err=1 only after ERR, otherwise 0.
  - resp_rdata changes only on successful loads. It holds its value across stores and errors.
- Latency from accept edge to the resp_valid cycle:
  - Load: MEM_LATENCY+1.
  - Word store: 2.
  - Partial store: MEM_LATENCY+2.
  - Error: 2.
- Back-to-back: req_ready=1 in the cycle after RESP, so the next accept is at the earliest on the edge that ends that cycle. No request is dropped while req_valid is held.
- req_* changes while busy are ignored. Fields are latched at accept only.

Test Plan:
- MEM_LATENCY=2, mem[0x100]=0xAABBCCDD, load byte at 0x103 -> mem_addr=0x100, resp_valid 3 cycles after accept, resp_rdata=0x000000AA, resp_err=0; load half at 0x102 -> 0x0000AABB.
- mem[0x200]=0x11223344, store half wdata=0x00001234 at 0x202 -> one read, then mem_wr high exactly 1 cycle with mem_addr=0x200, mem_wdata=0x12343344; resp_valid 4 cycles after accept.
- Store word 0xDEADBEEF at 0x300 -> no READ, mem_wr in the cycle after accept with mem_wdata=0xDEADBEEF; resp_valid 2 cycles after accept.
- Load word at 0x401, store half at 0x203, any access with size=00 -> resp_err=1, mem_wr never high, resp_rdata unchanged from the previous load.
- Store byte at 0x201; assert reset low during the 2nd READ cycle -> all outputs 0 immediately, mem_wr never asserted, memory unchanged; after release, a load at 0x200 returns the original word.
- req_valid held high with two loads queued -> second accept on the edge ending the cycle after resp_valid; busy high continuously except that one IDLE cycle.

Source files
------------

// File: rtl/ls_access_sequencer_if.sv
// Bus bundle between the load/store sequencer, the CPU control unit and the
// single-port data memory.
//
// Request handshake: a request transfers on a rising clock edge where both
// req_valid and req_ready are high. The request fields are sampled only on
// that edge. resp_valid is a one-cycle pulse, and resp_err and resp_rdata
// are meaningful only while it is high. The response is never back-pressured.
interface ls_access_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    // Environment side: the CPU control unit plus the data memory.
    modport master (
        output req_valid, req_write, req_size, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wr, mem_wdata
    );

    // Sequencer side.
    modport slave (
        input  req_valid, req_write, req_size, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wr, mem_wdata
    );
endinterface

// File: rtl/ls_access_sequencer.sv
// Load/store access sequencer. It turns byte, half and word requests into
// accesses on a single-port, word-wide data memory. Partial stores are done
// as read-modify-write. Loads return the addressed lane zero-extended.
// Misaligned or illegal-size requests complete with resp_err and never touch
// memory. MEM_LATENCY must be at least 1, and CNT_W must be wide enough to
// hold MEM_LATENCY-1.
module ls_access_sequencer #(
    parameter int MEM_LATENCY = 2,
    parameter int CNT_W       = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    ls_access_sequencer_if.slave bus,
    output logic                 busy,
    output logic [2:0]           state_dbg
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WRITE = 3'd2,
        RESP  = 3'd3,
        ERR   = 3'd4
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             ready_q;
    logic             write_q;
    logic [1:0]       size_q;
    logic [1:0]       off_q;
    logic [15:0]      wdata_q;
    logic             accept;
    logic             misaligned;
    logic [31:0]      load_lane;
    logic [31:0]      merged;

    assign accept        = bus.req_valid && ready_q;
    assign bus.req_ready = ready_q;
    assign busy          = (state != IDLE);
    assign state_dbg     = state;

    // Classify the incoming request: illegal size or a lane that crosses its natural alignment.
    always_comb begin
        misaligned = 1'b0;
        case (bus.req_size)
            2'b00:   misaligned = 1'b1;
            2'b10:   misaligned = bus.req_addr[0];
            2'b11:   misaligned = |bus.req_addr[1:0];
            default: misaligned = 1'b0;
        endcase
    end

    // Pick the addressed lane out of the read word, and build the read-modify-write merge word.
    always_comb begin
        load_lane = bus.mem_rdata;
        merged    = bus.mem_rdata;
        case (size_q)
            2'b01: begin
                load_lane = {24'b0, bus.mem_rdata[{off_q, 3'b000} +: 8]};
                merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
            end
            2'b10: begin
                load_lane = {16'b0, bus.mem_rdata[{off_q[1], 4'b0000} +: 16]};
                merged[{off_q[1], 4'b0000} +: 16] = wdata_q;
            end
            default: begin
                load_lane = bus.mem_rdata;
                merged    = bus.mem_rdata;
            end
        endcase
    end

    // Sequencer FSM with registered bus outputs. Reset aborts any access in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            cnt            <= '0;
            ready_q        <= 1'b0;
            write_q        <= 1'b0;
            size_q         <= 2'b00;
            off_q          <= 2'b00;
            wdata_q        <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= '0;
            bus.mem_addr   <= '0;
            bus.mem_wr     <= 1'b0;
            bus.mem_wdata  <= '0;
        end else begin
            bus.resp_valid <= 1'b0;
            bus.mem_wr     <= 1'b0;
            case (state)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        ready_q      <= 1'b0;
                        write_q      <= bus.req_write;
                        size_q       <= bus.req_size;
                        off_q        <= bus.req_addr[1:0];
                        wdata_q      <= bus.req_wdata[15:0];
                        bus.mem_addr <= {bus.req_addr[31:2], 2'b00};
                        bus.resp_err <= 1'b0;
                        if (misaligned) begin
                            state <= ERR;
                        end else if (bus.req_write && bus.req_size == 2'b11) begin
                            // A full word needs no read, so it goes straight to memory.
                            bus.mem_wdata <= bus.req_wdata;
                            bus.mem_wr    <= 1'b1;
                            state         <= WRITE;
                        end else begin
                            cnt   <= CNT_W'(MEM_LATENCY - 1);
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    if (cnt == '0) begin
                        if (write_q) begin
                            bus.mem_wdata <= merged;
                            bus.mem_wr    <= 1'b1;
                            state         <= WRITE;
                        end else begin
                            bus.resp_rdata <= load_lane;
                            bus.resp_valid <= 1'b1;
                            state          <= RESP;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WRITE: begin
                    bus.resp_valid <= 1'b1;
                    state          <= RESP;
                end
                ERR: begin
                    bus.resp_err   <= 1'b1;
                    bus.resp_valid <= 1'b1;
                    state          <= RESP;
                end
                RESP: begin
                    bus.resp_err <= 1'b0;
                    ready_q      <= 1'b1;
                    state        <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
